// File: rtl/uart_msg_tx.sv
// uart_msg_tx: streams a writable byte buffer into the UART tx_en/tx_rdy handshake,
// one-shot or repeating with an idle gap. Define UART_MSG_CRLF_EN to append CR/LF per pass.
module uart_msg_tx #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned GAP_W      = 26,
  parameter int unsigned GAP_CYCLES = 50000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          repeat_en,
  input  logic [AW:0]   msg_len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          tx_rdy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   byte_cnt
);

  localparam int unsigned LW = AW + 1;
`ifdef UART_MSG_CRLF_EN
  localparam int unsigned TermBytes = 2;
`else
  localparam int unsigned TermBytes = 0;
`endif

  typedef enum logic [2:0] {StIdle, StSend, StAck, StEnd, StGap} state_e;

  state_e           state_q, state_d;
  logic [7:0]       buf_q [DEPTH];
  logic [LW-1:0]    len_q, len_d, idx_q, idx_d;
  logic [LW-1:0]    last_idx, len_clamped;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             stop_seen_q, stop_seen_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_data_q, tx_data_d, cur_byte;
  logic [15:0]      cnt_q, cnt_d;

  // Buffer is deliberately not reset; a same-cycle write is seen by the next read only.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= wr_data;
  end

  assign len_clamped = (msg_len > LW'(DEPTH)) ? LW'(DEPTH) : msg_len;
  assign last_idx    = len_q + LW'(TermBytes) - LW'(1);

`ifdef UART_MSG_CRLF_EN
  always_comb begin
    if (idx_q < len_q)       cur_byte = buf_q[idx_q[AW-1:0]];
    else if (idx_q == len_q) cur_byte = 8'h0D;
    else                     cur_byte = 8'h0A;
  end
`else
  assign cur_byte = buf_q[idx_q[AW-1:0]];
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    stop_seen_d = stop_seen_q;
    tx_en_d     = tx_en_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (start && (msg_len != '0)) begin
          len_d       = len_clamped;
          idx_d       = '0;
          stop_seen_d = 1'b0;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (stop) begin
          state_d = StIdle;
        end else if (tx_rdy) begin
          tx_en_d   = 1'b1;
          tx_data_d = cur_byte;
          cnt_d     = cnt_q + 16'd1;
          state_d   = StAck;
        end
      end
      StAck: begin
        // A stop here only takes effect once the UART has acknowledged the byte.
        if (stop) stop_seen_d = 1'b1;
        if (!tx_rdy) begin
          tx_en_d = 1'b0;
          if (stop || stop_seen_q) begin
            stop_seen_d = 1'b0;
            state_d     = StIdle;
          end else if (idx_q == last_idx) begin
            state_d = StEnd;
          end else begin
            idx_d   = idx_q + LW'(1);
            state_d = StSend;
          end
        end
      end
      StEnd: begin
        if (repeat_en) begin
          gap_d   = '0;
          state_d = StGap;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StIdle;
        end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          idx_d   = '0;
          state_d = StSend;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      stop_seen_q <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      stop_seen_q <= stop_seen_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StEnd);
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: a UART responder model logs bytes and timing; expected streams are
// built from a mirror of the written buffer. Honours UART_MSG_CRLF_EN for terminator bytes.
module tb_uart_msg_tx;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned AW         = 4;
  localparam int unsigned GAP_W      = 26;
  localparam int unsigned GAP_CYCLES = 20;
`ifdef UART_MSG_CRLF_EN
  localparam int unsigned TERM = 2;
`else
  localparam int unsigned TERM = 0;
`endif

  logic          clk, rst, start, stop, repeat_en, wr_en, tx_rdy;
  logic [AW:0]   msg_len;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, tx_data;
  logic          tx_en, busy, done;
  logic [15:0]   byte_cnt;

  uart_msg_tx #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .GAP_W     (GAP_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .repeat_en(repeat_en),
    .msg_len  (msg_len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tx_rdy   (tx_rdy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .byte_cnt (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cycle = 0;
  int          done_cnt = 0;
  int unsigned done_q[$];
  int unsigned rise_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  buf_model[DEPTH];
  bit          uart_hold = 1'b0;
  int unsigned ack_delay = 0;
  int unsigned drop_delay = 0;
  int unsigned exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART responder: logs each new byte, holds tx_rdy for drop_delay cycles, then keeps it
  // low for ack_delay cycles.
  initial begin
    bit          prev_en = 1'b0;
    bit          pend = 1'b0;
    bit          rise;
    int unsigned drop_left = 0;
    int unsigned ack_left = 0;
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (rst) begin
        pend    = 1'b0;
        ack_left = 0;
        prev_en = 1'b0;
        tx_rdy  = !uart_hold;
      end else begin
        if (done === 1'b1) begin
          done_cnt++;
          done_q.push_back(cycle);
        end
        rise    = (tx_en === 1'b1) && !prev_en;
        prev_en = (tx_en === 1'b1);
        if (rise) begin
          rise_q.push_back(cycle);
          rx_q.push_back(tx_data);
        end
        if (uart_hold) begin
          tx_rdy   = 1'b0;
          pend     = 1'b0;
          ack_left = 0;
        end else if (rise || pend) begin
          if (rise) begin
            pend      = 1'b1;
            drop_left = drop_delay;
          end
          if (drop_left == 0) begin
            tx_rdy   = 1'b0;
            pend     = 1'b0;
            ack_left = ack_delay;
          end else begin
            drop_left--;
          end
        end else if (!tx_rdy) begin
          if (ack_left == 0) tx_rdy = 1'b1;
          else ack_left--;
        end
      end
    end
  end

  task automatic clear_logs();
    rx_q.delete();
    done_q.delete();
    rise_q.delete();
    done_cnt = 0;
  endtask

  task automatic wr(input int unsigned addr, input logic [7:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    buf_model[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic kick(input int unsigned len);
    @(negedge clk);
    msg_len = (AW + 1)'(len);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  // Reference: one pass is the first min(len,DEPTH) buffer bytes plus optional CR/LF.
  task automatic expect_msg(input string tag, input int unsigned len, input int unsigned passes);
    logic [7:0]  e[$];
    int unsigned n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int p = 0; p < int'(passes); p++) begin
      for (int i = 0; i < int'(n); i++) e.push_back(buf_model[i]);
      if (TERM != 0) begin
        e.push_back(8'h0D);
        e.push_back(8'h0A);
      end
    end
    check({tag, " nbytes"}, 32'(rx_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < rx_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(e[i]));
    exp_cnt += passes * (n + TERM);
    check({tag, " byte_cnt"}, 32'(byte_cnt), 32'(exp_cnt & 32'hFFFF));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bpp;
    int          n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0; msg_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst tx_en", 32'(tx_en), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst byte_cnt", 32'(byte_cnt), 32'd0);
    rst = 1'b0;

    // One-shot "Hi!" with slow acknowledge.
    wr(0, 8'h48); wr(1, 8'h69); wr(2, 8'h21);
    clear_logs(); ack_delay = 10; drop_delay = 0;
    kick(3);
    wait_idle("hi", 2000);
    expect_msg("hi", 3, 1);
    check("hi done", 32'(done_cnt), 32'd1);

    // Single byte: terminator bytes only with the CR/LF build.
    wr(0, 8'h41);
    clear_logs(); ack_delay = 1;
    kick(1);
    wait_idle("one", 2000);
    expect_msg("one", 1, 1);
    check("one done", 32'(done_cnt), 32'd1);

    // Repeat mode: three passes, gap timed from each done pulse.
    wr(0, 8'($urandom)); wr(1, 8'($urandom));
    clear_logs(); ack_delay = 2; bpp = 2 + TERM;
    repeat_en = 1'b1;
    kick(2);
    n = 0;
    while (done_cnt < 2 && n < 2000) begin @(negedge clk); n++; end
    while (rise_q.size() <= 2 * bpp && n < 4000) begin @(negedge clk); n++; end
    check("rep pass3 start", 32'(rise_q.size() > 2 * bpp), 32'd1);
    repeat_en = 1'b0;
    wait_idle("rep", 2000);
    expect_msg("rep", 2, 3);
    check("rep done", 32'(done_cnt), 32'd3);
    for (int p = 1; p < 3; p++)
      if (rise_q.size() > p * bpp && done_q.size() >= p)
        check($sformatf("rep gap%0d", p), rise_q[p * bpp] - done_q[p - 1], GAP_CYCLES + 2);

    // Stop during ACK of byte 1 of 4: byte 1 completes, nothing more, no done.
    for (int i = 0; i < 4; i++) wr(i, 8'($urandom));
    clear_logs(); ack_delay = 10; drop_delay = 3;
    kick(4);
    n = 0;
    while (rise_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("stop", 2000);
    repeat (20) @(negedge clk);
    check("stop nbytes", 32'(rx_q.size()), 32'd2);
    check("stop done", 32'(done_cnt), 32'd0);
    check("stop busy", 32'(busy), 32'd0);
    exp_cnt += 2;
    check("stop byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
    drop_delay = 0;

    // msg_len = 0 is ignored.
    clear_logs();
    kick(0);
    repeat (5) @(negedge clk);
    check("len0 busy", 32'(busy), 32'd0);
    check("len0 nbytes", 32'(rx_q.size()), 32'd0);
    check("len0 done", 32'(done_cnt), 32'd0);

    // tx_rdy held low: stays in SEND; a second start is ignored.
    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33);
    clear_logs(); uart_hold = 1'b1; ack_delay = 0;
    kick(3);
    repeat (10) @(negedge clk);
    check("hold busy", 32'(busy), 32'd1);
    check("hold tx_en", 32'(tx_en), 32'd0);
    check("hold nbytes", 32'(rx_q.size()), 32'd0);
    kick(5);
    uart_hold = 1'b0;
    wait_idle("hold", 2000);
    repeat (10) @(negedge clk);
    expect_msg("hold", 3, 1);
    check("hold done", 32'(done_cnt), 32'd1);

    // Stop while waiting in SEND returns to idle without sending.
    clear_logs(); uart_hold = 1'b1;
    kick(3);
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("sstop busy", 32'(busy), 32'd0);
    uart_hold = 1'b0;
    repeat (5) @(negedge clk);
    check("sstop nbytes", 32'(rx_q.size()), 32'd0);

    // Over-long msg_len is clamped to DEPTH.
    for (int i = 0; i < int'(DEPTH); i++) wr(i, 8'($urandom));
    clear_logs(); ack_delay = 0;
    kick(DEPTH + 5);
    wait_idle("clamp", 3000);
    expect_msg("clamp", DEPTH + 5, 1);

    // Randomised one-shot messages.
    for (int t = 0; t < 4; t++) begin
      int unsigned len;
      for (int k = 0; k < 4; k++) wr($urandom_range(DEPTH - 1, 0), 8'($urandom));
      len        = $urandom_range(2 * DEPTH - 1, 1);
      ack_delay  = $urandom_range(4, 0);
      drop_delay = $urandom_range(2, 0);
      clear_logs();
      kick(len);
      wait_idle($sformatf("rnd%0d", t), 3000);
      expect_msg($sformatf("rnd%0d", t), len, 1);
      check($sformatf("rnd%0d done", t), 32'(done_cnt), 32'd1);
    end

    // Asynchronous reset in the middle of an ACK.
    clear_logs(); ack_delay = 20; drop_delay = 5;
    kick(4);
    n = 0;
    while (rise_q.size() < 1 && n < 2000) begin @(negedge clk); n++; end
    check("mid tx_en before", 32'(tx_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid tx_en", 32'(tx_en), 32'd0);
    check("mid busy", 32'(busy), 32'd0);
    check("mid byte_cnt", 32'(byte_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; ack_delay = 0; drop_delay = 0;
    repeat (3) @(negedge clk);
    clear_logs();
    kick(2);
    wait_idle("post", 2000);
    expect_msg("post", 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
